// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg
//   Shared default constants for the ring_counter block.
//   RC_WIDTH_DEF     : default ring length in bits
//   RC_RESET_VAL_DEF : default one-hot pattern loaded on reset (LSB set)
package ring_counter_pkg;

  localparam int          RC_WIDTH_DEF     = 3;
  localparam logic [31:0] RC_RESET_VAL_DEF = 32'd1;

endpackage : ring_counter_pkg

// File: rtl/ring_counter.sv
// ring_counter
//   One-hot ring counter. The hot bit rotates left by one position on every
//   rising clk edge while clr is high. clr low asynchronously loads RESET_VAL.
//   With SELF_CORRECT set, an illegal (non one-hot) state is replaced by
//   RESET_VAL on the next edge instead of being rotated.
//
// Parameters
//   WIDTH        : ring length in bits, 2..32
//   RESET_VAL    : one-hot reset pattern (exactly one bit set within WIDTH)
//   SELF_CORRECT : 1 = recover from illegal states, 0 = rotate them as-is
// Ports
//   clk  : in  1     single clock, rising edge
//   clr  : in  1     asynchronous active-low reset
//   Q    : out WIDTH ring state, straight from the state register
//   wrap : out 1     high while Q holds the MSB-only pattern
//   err  : out 1     high while Q is not one-hot (zero or several bits set)
module ring_counter
  import ring_counter_pkg::*;
#(
  parameter int          WIDTH        = RC_WIDTH_DEF,
  parameter logic [31:0] RESET_VAL    = RC_RESET_VAL_DEF,
  parameter bit          SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  output logic [WIDTH-1:0] Q,
  output logic             wrap,
  output logic             err
);

  // Exactly-one-bit-set test over a 32-bit value. Narrower vectors are
  // zero-extended by the caller, which does not change the bit count.
  function automatic logic onehot32(input logic [31:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return (cnt == 32'd1);
  endfunction

  localparam logic [WIDTH-1:0] RST_Q  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] WRAP_Q = {1'b1, {(WIDTH-1){1'b0}}};

  // Parameter legality, checked when the design is elaborated.
  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("ring_counter: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (!onehot32(RESET_VAL) || ((RESET_VAL >> WIDTH) != 32'd0)) begin : g_bad_reset_val
    $error("ring_counter: RESET_VAL=%0h is not one-hot within WIDTH=%0d", RESET_VAL, WIDTH);
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_s;
  logic             err_s;

  // Status decode: both flags are pure functions of the current state.
  always_comb begin
    wrap_s = 1'b0;
    err_s  = 1'b0;
    if (q_r == WRAP_Q) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
    if (onehot32(32'(q_r))) begin
      err_s = 1'b0;
    end else begin
      err_s = 1'b1;
    end
  end

  // Ring state: async load of the reset pattern, otherwise rotate left.
  // Rotation is plain bit wiring (MSB wraps into bit 0).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_r <= RST_Q;
    end else if (SELF_CORRECT && err_s) begin
      q_r <= RST_Q;
    end else begin
      q_r <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
    end
  end

  assign Q    = q_r;
  assign wrap = wrap_s;
  assign err  = err_s;

endmodule : ring_counter

// File: tb/tb_ring_counter.sv
// tb_ring_counter
//   Directed plus randomized bench for ring_counter. Three instances share
//   clk/clr: defaults (WIDTH=3, self-correcting), WIDTH=3 without
//   self-correction, and WIDTH=5. The reference model tracks only the index
//   of the hot bit per instance, plus a flag for a deliberately injected
//   illegal state.
module tb_ring_counter;

  logic       clk;
  logic       clr;
  logic [2:0] q3;
  logic       wrap3;
  logic       err3;
  logic [2:0] qn;
  logic       wrapn;
  logic       errn;
  logic [4:0] q5;
  logic       wrap5;
  logic       err5;

  int checks;
  int errors;

  // reference model: hot-bit index per instance, illegal-state flags
  int p3;
  int pn;
  int p5;
  bit bad3;
  bit badn;
  int wraps;

  ring_counter dut (
    .clk (clk),
    .clr (clr),
    .Q   (q3),
    .wrap(wrap3),
    .err (err3)
  );

  ring_counter #(.WIDTH(3), .RESET_VAL(32'd1), .SELF_CORRECT(1'b0)) dut_nc (
    .clk (clk),
    .clr (clr),
    .Q   (qn),
    .wrap(wrapn),
    .err (errn)
  );

  ring_counter #(.WIDTH(5), .RESET_VAL(32'd1), .SELF_CORRECT(1'b1)) dut5 (
    .clk (clk),
    .clr (clr),
    .Q   (q5),
    .wrap(wrap5),
    .err (err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    // default instance
    if (bad3) begin
      check({tag, ":q3"},    {29'd0, q3}, 32'h3);
      check({tag, ":err3"},  {31'd0, err3}, 32'd1);
      check({tag, ":wrap3"}, {31'd0, wrap3}, 32'd0);
    end else begin
      check({tag, ":q3"},    {29'd0, q3}, 32'd1 << p3);
      check({tag, ":err3"},  {31'd0, err3}, 32'd0);
      check({tag, ":wrap3"}, {31'd0, wrap3}, (p3 == 2) ? 32'd1 : 32'd0);
    end
    // no self-correction instance
    if (badn) begin
      check({tag, ":qn"},    {29'd0, qn}, 32'd0);
      check({tag, ":errn"},  {31'd0, errn}, 32'd1);
      check({tag, ":wrapn"}, {31'd0, wrapn}, 32'd0);
    end else begin
      check({tag, ":qn"},    {29'd0, qn}, 32'd1 << pn);
      check({tag, ":errn"},  {31'd0, errn}, 32'd0);
      check({tag, ":wrapn"}, {31'd0, wrapn}, (pn == 2) ? 32'd1 : 32'd0);
    end
    // WIDTH=5 instance
    check({tag, ":q5"},    {27'd0, q5}, 32'd1 << p5);
    check({tag, ":err5"},  {31'd0, err5}, 32'd0);
    check({tag, ":wrap5"}, {31'd0, wrap5}, (p5 == 4) ? 32'd1 : 32'd0);
  endtask

  // one clock edge, then advance the model and compare
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (clr) begin
      if (bad3) p3 = 0;
      else      p3 = (p3 + 1) % 3;
      bad3 = 1'b0;
      if (!badn) pn = (pn + 1) % 3;
      p5 = (p5 + 1) % 5;
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    p3   = 0;
    pn   = 0;
    p5   = 0;
    bad3 = 1'b0;
    badn = 1'b0;
  endtask

  logic [2:0] seq [6];

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b001;
    seq[3] = 3'b010; seq[4] = 3'b100; seq[5] = 3'b001;

    // reset held with clk running
    clr = 1'b0;
    #10;
    check_all("reset");
    step("reset_hold");

    // release away from the clock edge, then six edges
    #2;
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("run");
      check("seq", {29'd0, q3}, {29'd0, seq[i]});
    end

    // reach the wrap state, then drop clr mid-cycle
    for (int i = 0; i < 3 && p3 != 2; i++) step("to_wrap");
    check("at_wrap", {31'd0, wrap3}, 32'd1);
    #3;
    clr = 1'b0;
    #1;
    model_reset();
    check_all("async_clr");
    check("async_q", {29'd0, q3}, 32'd1);
    #1;
    clr = 1'b1;
    step("after_async");
    check("after_async_q", {29'd0, q3}, 32'd2);

    // illegal 011 in the self-correcting instance
    force dut.q_r = 3'b011;
    bad3 = 1'b1;
    #1;
    check_all("forced_011");
    release dut.q_r;
    step("self_correct");
    check("self_correct_q", {29'd0, q3}, 32'd1);

    // illegal 000 in the non-correcting instance stays stuck
    force dut_nc.q_r = 3'b000;
    badn = 1'b1;
    #1;
    check_all("forced_000");
    release dut_nc.q_r;
    for (int i = 0; i < 4; i++) step("stuck_000");

    // async pulse brings everything back to the reset pattern
    #3;
    clr = 1'b0;
    #1;
    model_reset();
    check_all("resync");
    #1;
    clr = 1'b1;

    // WIDTH=5: 10 edges contain exactly two wrap states
    wraps = 0;
    for (int i = 0; i < 10; i++) begin
      step("w5");
      wraps = wraps + int'(wrap5);
    end
    check("w5_wraps", 32'(wraps), 32'd2);

    // randomized edges with occasional mid-cycle reset pulses
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        #($urandom_range(1, 3));
        clr = 1'b0;
        #1;
        model_reset();
        check_all("rand_clr");
        #1;
        clr = 1'b1;
      end else begin
        step("rand_step");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ring_counter

// File: doc/ring_counter.md
RING_COUNTER -- requirements
Module: ring_counter

Interface
REQ-001 The parameter WIDTH SHALL default to 3 and set the ring length in bits; legal values are 2..32.
REQ-002 The parameter RESET_VAL SHALL default to 1 (LSB set) and set the one-hot pattern loaded on reset; it must contain exactly one set bit.
REQ-003 The parameter SELF_CORRECT SHALL default to 1; 1 enables recovery from illegal states, 0 disables it.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-005 Port clr SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-006 Port Q SHALL be an output, WIDTH bits wide: the ring state, driven directly from a register.
REQ-007 Port wrap SHALL be an output, 1 bit wide: high while Q equals the MSB-only pattern (last state before wrap-around).
REQ-008 Port err SHALL be an output, 1 bit wide: high while Q is not one-hot (zero or multiple bits set).

Function
REQ-009 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low on clr.
REQ-010 While clr=1, every rising clk edge SHALL rotate Q left by one bit: Q[0] takes the old Q[WIDTH-1]; Q[i] takes the old Q[i-1].
REQ-011 With defaults, the sequence after reset release SHALL be 001 -> 010 -> 100 -> 001 -> ..., with period WIDTH cycles.
REQ-012 Latency from the clk edge to the new Q value SHALL be one cycle; the block has no enable and advances every cycle.
REQ-013 wrap SHALL be combinational from Q: 1 exactly when Q == (1 << (WIDTH-1)).
REQ-014 err SHALL be combinational from Q: 1 when popcount(Q) != 1.
REQ-015 With SELF_CORRECT=1, an edge that samples an illegal Q (err=1) SHALL load RESET_VAL instead of rotating.
REQ-016 With SELF_CORRECT=0, an illegal Q SHALL rotate like a legal one and keep err asserted.
REQ-017 Rotation SHALL be pure bit wiring; no arithmetic, and no width growth.

Reset
REQ-018 clr=0 SHALL force Q to RESET_VAL immediately, independent of clk.
REQ-019 During reset, wrap and err SHALL take the values implied by RESET_VAL (defaults: wrap=0, err=0).
REQ-020 While clr=0, Q SHALL hold RESET_VAL across any number of clk edges.
REQ-021 Reset asserted mid-sequence (including in the wrap state) SHALL override rotation; on the first clk edge after clr rises, Q SHALL move from RESET_VAL to its left rotation.
REQ-022 A clr release coincident with a clk edge SHALL leave Q at RESET_VAL for that edge; the clr deassertion must be synchronized upstream.

Structure
REQ-023 The block SHALL be a single module with no sub-modules; the popcount/one-hot check SHALL be a local function.
REQ-024 A shared package ring_counter_pkg SHALL hold the default constants RC_WIDTH_DEF=3 and RC_RESET_VAL_DEF=1; no typedefs are required.
REQ-025 The RTL SHALL include parameter-legality checks (WIDTH range, RESET_VAL one-hot) as elaboration-time assertions.

Verification
REQ-026 Bench clock period SHALL be 10 ns; hold clr=0 for 10 ns -> Q=001, wrap=0, err=0, with clk toggling.
REQ-027 Release clr, run 6 edges -> Q = 010, 100, 001, 010, 100, 001, with wrap=1 only while Q=100.
REQ-028 Drop clr asynchronously mid-cycle while Q=100 -> Q=001 before the next clk edge; after release, the next edge gives Q=010.
REQ-029 Force Q=011 (SELF_CORRECT=1) -> err=1, and the next edge gives Q=001, err=0.
REQ-030 Force Q=000 (SELF_CORRECT=0) -> err stays 1 and Q stays 000 across 4 edges.
REQ-031 Run WIDTH=5 for 10 edges -> period 5 observed, wrap high when Q=10000; every cycle SHALL be checked against a reference model.
